// File: rtl/sb_codex_pkg.sv
// Shared sideband message types and defaults used by the LTSM sub-state modules
// and the sideband TX path.
package SB_codex_pkg;

    localparam int SB_RETRY_PERIOD_DEFAULT = 800;

    typedef enum logic [7:0] {
        SB_NO_MSG                = 8'd0,
        SBINIT_out_of_reset      = 8'd1,
        SBINIT_done_req          = 8'd2,
        SBINIT_done_resp         = 8'd3,
        MBINIT_PARAM_config_req  = 8'd4,
        MBINIT_PARAM_config_resp = 8'd5
    } SB_msg_num_t;

    typedef struct packed {
        SB_msg_num_t msg_num;
        logic [15:0] msg_info;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.msg_num  = SB_NO_MSG;
        m.msg_info = '0;
        return m;
    endfunction

endpackage

// File: rtl/sb_tx_arbiter_retry_timer.sv
// Free-running retry timer: pulses flag once every RETRY_PERIOD enabled cycles.
module sb_retry_timer
    import SB_codex_pkg::*;
#(
    parameter int RETRY_PERIOD = SB_RETRY_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic flag
);

    localparam int CW = $clog2(RETRY_PERIOD);

    logic [CW-1:0] cnt;

    // Clear outranks enable so a requester restarting its handshake never sees a stale pulse.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else if (en) begin
            if (cnt == CW'(RETRY_PERIOD - 1)) begin
                cnt  <= '0;
                flag <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                flag <= 1'b0;
            end
        end else begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX port between LTSM sub-state modules,
// with a one-entry holding register and one retry timer per requester.
module sb_tx_arbiter
    import SB_codex_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int RETRY_PERIOD = SB_RETRY_PERIOD_DEFAULT
) (
    input  logic                           clk_100MHz,
    input  logic                           reset,
    input  SB_msg_t [N_REQ-1:0]            req_msg_i,
    input  logic    [N_REQ-1:0][63:0]      req_data_i,
    input  logic    [N_REQ-1:0]            req_valid_i,
    output logic    [N_REQ-1:0]            req_accept_o,
    input  logic    [N_REQ-1:0]            retry_en_i,
    input  logic    [N_REQ-1:0]            retry_clr_i,
    output logic    [N_REQ-1:0]            retry_flag_o,
    output SB_msg_t                        tx_msg_o,
    output logic    [63:0]                 tx_data_o,
    output logic                           tx_valid_o,
    input  logic                           tx_ready_i,
    output logic    [$clog2(N_REQ)-1:0]    grant_id_o,
    output logic                           busy_o
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    arb_state_t           state, state_nxt;
    logic [IW-1:0]        rr_ptr, rr_nxt;
    logic [IW-1:0]        grant_nxt;
    logic [N_REQ-1:0]     accept_nxt;
    SB_msg_t              msg_nxt;
    logic [63:0]          data_nxt;

    logic                 found;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        cand;
    logic [IW:0]          sum;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant_id_o   <= '0;
            req_accept_o <= '0;
            tx_msg_o     <= reset_SB_msg();
            tx_data_o    <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            grant_id_o   <= grant_nxt;
            req_accept_o <= accept_nxt;
            tx_msg_o     <= msg_nxt;
            tx_data_o    <= data_nxt;
        end
    end

    // Round-robin scan starting at rr_ptr; modulo done by subtraction so any N_REQ works.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            cand = sum[IW-1:0];
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        grant_nxt  = grant_id_o;
        accept_nxt = '0;
        msg_nxt    = tx_msg_o;
        data_nxt   = tx_data_o;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt        = ST_HOLD;
                    msg_nxt          = req_msg_i[pick];
                    data_nxt         = req_data_i[pick];
                    accept_nxt[pick] = 1'b1;
                    grant_nxt        = pick;
                    rr_nxt           = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            ST_HOLD: begin
                // Requests are ignored here; the held message goes out regardless.
                if (tx_ready_i) begin
                    state_nxt = ST_IDLE;
                    msg_nxt   = reset_SB_msg();
                    data_nxt  = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tx_valid_o = (state == ST_HOLD);
    assign busy_o     = (state == ST_HOLD);

    for (genvar k = 0; k < N_REQ; k++) begin : g_retry
        sb_retry_timer #(
            .RETRY_PERIOD(RETRY_PERIOD)
        ) u_retry_timer (
            .clk   (clk_100MHz),
            .reset (reset),
            .en    (retry_en_i[k]),
            .clr   (retry_clr_i[k]),
            .flag  (retry_flag_o[k])
        );
    end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter with a grant scoreboard and retry-timer checks.
module tb_sb_tx_arbiter;
    import SB_codex_pkg::*;

    localparam int N  = 4;
    localparam int RP = 8;

    logic                    clk_100MHz = 1'b0;
    logic                    reset;
    SB_msg_t [N-1:0]         req_msg;
    logic    [N-1:0][63:0]   req_data;
    logic    [N-1:0]         req_valid;
    logic    [N-1:0]         req_accept;
    logic    [N-1:0]         retry_en;
    logic    [N-1:0]         retry_clr;
    logic    [N-1:0]         retry_flag;
    SB_msg_t                 tx_msg;
    logic    [63:0]          tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic    [1:0]           grant_id;
    logic                    busy;

    sb_tx_arbiter #(
        .N_REQ        (N),
        .RETRY_PERIOD (RP)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .req_msg_i    (req_msg),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_accept_o (req_accept),
        .retry_en_i   (retry_en),
        .retry_clr_i  (retry_clr),
        .retry_flag_o (retry_flag),
        .tx_msg_o     (tx_msg),
        .tx_data_o    (tx_data),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .grant_id_o   (grant_id),
        .busy_o       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int          id;
        SB_msg_t     msg;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic SB_msg_t mk_msg(input SB_msg_num_t n, input logic [15:0] info);
        SB_msg_t m;
        m.msg_num  = n;
        m.msg_info = info;
        return m;
    endfunction

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = id;
        e.msg  = req_msg[id];
        e.data = req_data[id];
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1ns later, and reconcile any accept with the scoreboard.
    task automatic step(input bit want_accept);
        exp_t e;
        @(posedge clk_100MHz);
        #1;
        chk("accept_present", 64'(|req_accept), 64'(want_accept));
        if (req_accept != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_accept", 64'(req_accept), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("accept_vec", 64'(req_accept), 64'd1 << e.id);
                chk("grant_id", 64'(grant_id), 64'(e.id));
                chk("grant_msg", 64'(tx_msg), 64'(e.msg));
                chk("grant_data", tx_data, e.data);
                chk("grant_valid", 64'(tx_valid), 64'd1);
            end
        end
    endtask

    initial begin
        SB_msg_t held_msg;
        logic [63:0] held_data;

        reset     = 1'b1;
        req_valid = '0;
        retry_en  = '0;
        retry_clr = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_msg[i]  = reset_SB_msg();
            req_data[i] = '0;
        end

        // Reset state
        step(0);
        step(0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_retry_flag", 64'(retry_flag), 64'd0);
        chk("rst_tx_msg", 64'(tx_msg), 64'(reset_SB_msg()));
        chk("rst_tx_data", tx_data, 64'd0);

        // Retry timer: pulses at 8, 16, 24 after reset release
        retry_en = 4'b0001;
        step(0);
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step(0);
            chk($sformatf("retry_a_c%0d", k), 64'(retry_flag), 64'((k % RP) == 0));
        end

        // Retry timer: clear (with enable still high) at cycle 12 moves next pulse to 20
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            retry_clr = (k == 12) ? 4'b0001 : 4'b0000;
            step(0);
            chk($sformatf("retry_b_c%0d", k), 64'(retry_flag), 64'((k == 8) || (k == 20)));
        end
        retry_clr = '0;
        retry_en  = '0;

        // Single request from requester 1, serializer stalls for 4 cycles
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        req_msg[1]  = mk_msg(SBINIT_out_of_reset, 16'h0011);
        req_data[1] = 64'h0000_0000_DEAD_BEEF;
        req_valid   = 4'b0010;
        push_exp(1);
        step(1);
        req_valid = '0;
        held_msg  = tx_msg;
        held_data = tx_data;
        for (int c = 2; c <= 4; c++) begin
            step(0);
            chk($sformatf("t1_valid_c%0d", c), 64'(tx_valid), 64'd1);
            chk($sformatf("t1_msg_c%0d", c), 64'(tx_msg), 64'(mk_msg(SBINIT_out_of_reset, 16'h0011)));
            chk($sformatf("t1_data_c%0d", c), tx_data, 64'h0000_0000_DEAD_BEEF);
        end
        chk("t1_busy", 64'(busy), 64'd1);
        tx_ready = 1'b1;
        step(0);
        chk("t1_valid_done", 64'(tx_valid), 64'd0);
        chk("t1_msg_done", 64'(tx_msg), 64'(reset_SB_msg()));
        chk("t1_data_done", tx_data, 64'd0);
        chk("t1_grant_id", 64'(grant_id), 64'd1);
        chk("t1_held_stable", {held_data[31:0], 8'h0, held_msg}, {32'hDEAD_BEEF, 8'h0, mk_msg(SBINIT_out_of_reset, 16'h0011)});

        // All four requesting continuously: grants 0,1,2,3,0 every other cycle
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        req_msg[0]  = mk_msg(SBINIT_done_req, 16'h0100);
        req_msg[1]  = mk_msg(SBINIT_done_resp, 16'h0101);
        req_msg[2]  = mk_msg(MBINIT_PARAM_config_req, 16'h0102);
        req_msg[3]  = mk_msg(MBINIT_PARAM_config_resp, 16'h0103);
        req_data[0] = 64'h1111_0000_0000_0000;
        req_data[1] = 64'h2222_0000_0000_0001;
        req_data[2] = 64'h3333_0000_0000_0002;
        req_data[3] = 64'h4444_0000_0000_0003;
        push_exp(0);
        push_exp(1);
        push_exp(2);
        push_exp(3);
        push_exp(0);
        req_valid = 4'b1111;
        tx_ready  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step((c % 2) == 1);
            chk($sformatf("rr_valid_c%0d", c), 64'(tx_valid), 64'((c % 2) == 1));
        end
        req_valid = '0;
        step(0);
        chk("rr_sb_drained", 64'(sb.size()), 64'd0);

        // Requester 2 drops valid and changes its inputs while held
        req_msg[2]  = mk_msg(MBINIT_PARAM_config_req, 16'h0222);
        req_data[2] = 64'h0000_2222_0000_2222;
        req_valid   = 4'b0100;
        tx_ready    = 1'b0;
        push_exp(2);
        step(1);
        req_valid   = '0;
        req_msg[2]  = mk_msg(SBINIT_done_resp, 16'hFFFF);
        req_data[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 1; c <= 2; c++) begin
            step(0);
            chk($sformatf("drop_msg_c%0d", c), 64'(tx_msg), 64'(mk_msg(MBINIT_PARAM_config_req, 16'h0222)));
            chk($sformatf("drop_data_c%0d", c), tx_data, 64'h0000_2222_0000_2222);
        end
        tx_ready = 1'b1;
        step(0);
        chk("drop_valid_done", 64'(tx_valid), 64'd0);
        step(0);
        step(0);
        chk("ready_idle_valid", 64'(tx_valid), 64'd0);
        chk("drop_grant_id", 64'(grant_id), 64'd2);

        // Reset while holding; after release the scan restarts at index 0
        req_msg[1]  = mk_msg(SBINIT_out_of_reset, 16'h0301);
        req_data[1] = 64'h0000_0000_0000_0301;
        req_msg[2]  = mk_msg(SBINIT_done_req, 16'h0302);
        req_data[2] = 64'h0000_0000_0000_0302;
        req_valid   = 4'b0110;
        tx_ready    = 1'b0;
        push_exp(1);
        step(1);
        reset = 1'b1;
        step(0);
        chk("rst_hold_valid", 64'(tx_valid), 64'd0);
        chk("rst_hold_msg", 64'(tx_msg), 64'(reset_SB_msg()));
        chk("rst_hold_data", tx_data, 64'd0);
        chk("rst_hold_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        push_exp(1);
        step(1);
        req_valid = '0;
        tx_ready  = 1'b1;
        step(0);
        chk("rst_after_valid", 64'(tx_valid), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
